// File: rtl/cdc_fifo_pkg.sv
// Shared pointer helpers and constants for the CDC descriptor FIFO controllers.
// Gray conversions run on a fixed 32-bit container; zero-extended inputs convert correctly at any narrower width.
package cdc_fifo_pkg;

  localparam int GRAY_MAX_W     = 32;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int PTR_W          = ADDR_WIDTH_DEF + 1;
  localparam logic [1:0] OCC_MAX = 2'd2;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/cdc_sync_bus.sv
// Multi-flop synchroniser for a Gray-coded bus; latency STAGES clk edges, no backpressure.
// Shared by the read- and write-side FIFO controllers.
module cdc_sync_bus #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_fifo_rd_ctrl.sv
// Read side of the CDC descriptor FIFO: write-pointer sync, empty/level, RAM fetch, 2-entry skid output.
// First word valid SYNC_STAGES+2 edges after the write pointer moves; fetch stops as soon as the skid would overflow. CDC_FIFO_RD_CHECK_EN adds the sticky pointer check.
module cdc_fifo_rd_ctrl
  import cdc_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   wptr_gray_i,
  output logic [ADDR_WIDTH:0]   rptr_gray_o,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  err_o
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0]         wsync_gray;
  logic [PW-1:0]         wsync_bin;
  logic [PW-1:0]         rptr_bin;
  logic [PW-1:0]         rptr_next;
  logic                  out_vld;
  logic                  skid_vld;
  logic [DATA_WIDTH-1:0] out_dat;
  logic [DATA_WIDTH-1:0] skid_dat;
  logic                  infl;
  logic                  pop;
  logic [1:0]            occ;
  logic [2:0]            occ_sum;

  cdc_sync_bus #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk (rd_clk),
    .rst (rst),
    .d   (wptr_gray_i),
    .q   (wsync_gray)
  );

  assign wsync_bin = PW'(gray2bin(GRAY_MAX_W'(wsync_gray)));
  assign empty     = (wsync_bin == rptr_bin);
  assign level     = wsync_bin - rptr_bin;

  assign occ     = {1'b0, out_vld} + {1'b0, skid_vld};
  assign pop     = out_vld & m_ready;
  // Entries that will be held once this cycle's pop and capture settle.
  assign occ_sum = {1'b0, occ} + {2'b0, infl} - {2'b0, pop};
  assign ram_re  = !rst && !empty && (occ_sum < {1'b0, OCC_MAX});

  assign rptr_next = rptr_bin + PW'(1);
  assign ram_raddr = rptr_bin[ADDR_WIDTH-1:0];
  assign m_valid   = out_vld;
  assign m_data    = out_dat;

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      rptr_bin    <= '0;
      rptr_gray_o <= '0;
      infl        <= 1'b0;
    end else begin
      infl <= ram_re;
      if (ram_re) begin
        rptr_bin    <= rptr_next;
        rptr_gray_o <= PW'(bin2gray(GRAY_MAX_W'(rptr_next)));
      end
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      out_dat  <= '0;
      skid_dat <= '0;
    end else if (pop) begin
      if (skid_vld) begin
        out_dat <= skid_dat;
        if (infl) skid_dat <= ram_dout;
        else      skid_vld <= 1'b0;
      end else if (infl) begin
        out_dat <= ram_dout;
      end else begin
        out_vld <= 1'b0;
      end
    end else if (infl) begin
      if (!out_vld) begin
        out_dat <= ram_dout;
        out_vld <= 1'b1;
      end else begin
        skid_dat <= ram_dout;
        skid_vld <= 1'b1;
      end
    end
  end

`ifdef CDC_FIFO_RD_CHECK_EN
  localparam logic [PW-1:0] FULL_LVL = PW'(1) << ADDR_WIDTH;

  logic [PW-1:0] wsync_prev;
  logic [PW-1:0] wsync_step;
  logic          over_lvl;
  logic          back_step;

  // A forward step larger than the RAM depth can only mean the pointer went backwards.
  assign wsync_step = wsync_bin - wsync_prev;
  assign over_lvl   = (level > FULL_LVL);
  assign back_step  = (wsync_step > FULL_LVL);

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      wsync_prev <= '0;
      err_o      <= 1'b0;
    end else begin
      wsync_prev <= wsync_bin;
      if (over_lvl || back_step) err_o <= 1'b1;
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_fifo_rd_ctrl.sv
// Directed bench for cdc_fifo_rd_ctrl with a behavioural RAM and a write-side pointer model.
module tb_cdc_fifo_rd_ctrl;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SS = 2;
  localparam int PW = AW + 1;
`ifdef CDC_FIFO_RD_CHECK_EN
  localparam logic CHK_ERR = 1'b1;
`else
  localparam logic CHK_ERR = 1'b0;
`endif

  logic          rd_clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] wptr_gray_i = '0;
  logic [PW-1:0] rptr_gray_o;
  logic [AW-1:0] ram_raddr;
  logic          ram_re;
  logic [DW-1:0] ram_dout;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          empty;
  logic [PW-1:0] level;
  logic          err_o;

  logic [DW-1:0] mem [16];
  logic [PW-1:0] wbin = '0;
  logic [DW-1:0] expq [$];
  int            errors = 0;
  int            checks = 0;

  cdc_fifo_rd_ctrl #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (SS)
  ) dut (
    .rd_clk      (rd_clk),
    .rst         (rst),
    .wptr_gray_i (wptr_gray_i),
    .rptr_gray_o (rptr_gray_o),
    .ram_raddr   (ram_raddr),
    .ram_re      (ram_re),
    .ram_dout    (ram_dout),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .empty       (empty),
    .level       (level),
    .err_o       (err_o)
  );

  always #5 rd_clk = ~rd_clk;

  always @(posedge rd_clk) begin
    if (ram_re) ram_dout <= mem[ram_raddr];
  end

  task automatic tick();
    @(posedge rd_clk);
    @(negedge rd_clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    mem[wbin[AW-1:0]] = d;
    expq.push_back(d);
    wbin = wbin + 5'd1;
    wptr_gray_i = wbin ^ (wbin >> 1);
  endtask

  // mode 1 toggles m_ready 1,0,0,1; mode 0 holds it high.
  task automatic drain(input string tag, input int mode, input int budget);
    int            cyc = 0;
    logic          stalled = 1'b0;
    logic [DW-1:0] held = '0;
    logic [PW-1:0] pg = rptr_gray_o;
    while (expq.size() > 0 && cyc < budget) begin
      m_ready = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (stalled) begin
        chk({tag, "_stall_vld"}, m_valid, 1'b1);
        chk({tag, "_stall_dat"}, m_data, held);
      end
      if (m_valid && m_ready) chk({tag, "_data"}, m_data, expq.pop_front());
      stalled = m_valid && !m_ready;
      held    = m_data;
      chk({tag, "_occ_le2"}, (dut.occ <= 2'd2), 1'b1);
      if (rptr_gray_o != pg) chk({tag, "_gray_1bit"}, $countones(rptr_gray_o ^ pg), 1);
      pg = rptr_gray_o;
      tick();
      cyc++;
    end
    chk({tag, "_left"}, expq.size(), 0);
    m_ready = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_data", m_data, 32'h0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_level", level, 5'd0);
    chk("rst_re", ram_re, 1'b0);
    chk("rst_rgray", rptr_gray_o, 5'd0);
    chk("rst_err", err_o, 1'b0);

    // Basic fill/drain: Gray pointer 0->1->3->2.
    m_ready = 1'b1;
    push(32'hA1);
    tick();
    chk("b_empty_e0", empty, 1'b1);
    push(32'hA2);
    tick();
    chk("b_empty_e1", empty, 1'b0);
    chk("b_re_e1", ram_re, 1'b1);
    chk("b_level_e1", level, 5'd1);
    push(32'hA3);
    tick();
    chk("b_vld_e2", m_valid, 1'b0);
    tick();
    chk("b_vld_e3", m_valid, 1'b1);
    chk("b_dat_a1", m_data, 32'hA1);
    tick();
    chk("b_dat_a2", m_data, 32'hA2);
    tick();
    chk("b_dat_a3", m_data, 32'hA3);
    tick();
    chk("b_vld_end", m_valid, 1'b0);
    chk("b_empty_end", empty, 1'b1);
    chk("b_level_end", level, 5'd0);
    chk("b_rgray_end", rptr_gray_o, 5'd2);
    expq.delete();

    // Back-pressure with 8 words.
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push(32'hB0 + i);
      tick();
    end
    repeat (6) tick();
    chk("bp_level", level, 5'd6);
    chk("bp_occ", dut.occ, 2'd2);
    chk("bp_re_full", ram_re, 1'b0);
    chk("bp_head", m_data, 32'hB0);
    drain("bp", 1, 100);

    // Full RAM behind a full output stage, three rounds to wrap the pointer.
    for (int r = 0; r < 3; r++) begin
      m_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
        push(32'hC000 + r * 32 + i);
        tick();
      end
      repeat (5) tick();
      for (int i = 2; i < 18; i++) begin
        push(32'hC000 + r * 32 + i);
        tick();
      end
      repeat (4) tick();
      chk("full_level", level, 5'd16);
      chk("full_empty", empty, 1'b0);
      chk("full_re", ram_re, 1'b0);
      drain("wrap", 0, 100);
    end
    chk("wrap_rgray", rptr_gray_o, 5'd1);

    // Reset with both output entries full and words still in the RAM.
    for (int i = 0; i < 4; i++) begin
      push(32'hD0 + i);
      tick();
    end
    repeat (5) tick();
    chk("mr_occ_pre", dut.occ, 2'd2);
    rst = 1'b1;
    m_ready = 1'b1;
    wbin = '0;
    wptr_gray_i = '0;
    expq.delete();
    tick();
    chk("mr_valid", m_valid, 1'b0);
    chk("mr_data", m_data, 32'h0);
    chk("mr_re", ram_re, 1'b0);
    chk("mr_rgray", rptr_gray_o, 5'd0);
    chk("mr_empty", empty, 1'b1);
    chk("mr_level", level, 5'd0);
    rst = 1'b0;
    m_ready = 1'b0;
    tick();
    push(32'hD1);
    drain("post_rst", 0, 20);

    // Pointer moving backwards from 5 to 3.
    for (int i = 2; i <= 5; i++) begin
      push(32'hE0 + i);
      tick();
    end
    drain("pre_err", 0, 30);
    repeat (3) tick();
    chk("err_idle", err_o, 1'b0);
    wbin = 5'd3;
    wptr_gray_i = 5'd2;
    tick();
    tick();
    chk("err_early", err_o, 1'b0);
    tick();
    chk("err_set", err_o, CHK_ERR);
    repeat (4) tick();
    chk("err_hold", err_o, CHK_ERR);
    rst = 1'b1;
    wbin = '0;
    wptr_gray_i = '0;
    tick();
    rst = 1'b0;
    tick();
    chk("err_clr", err_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
